// File: rtl/pong_timebase_display.sv
// rtl/pong_timebase_display.sv - clock dividers, serve-entropy bit and score seven-segment mux
//
// Purpose:
//   Derives the display strobe clock (clk_1k) and game-update clock (clk_10)
//   from the system clock, exposes the slow-counter LSB as serve-direction
//   entropy, and time-multiplexes the two player scores onto one 7-seg bus.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous active-high reset
//   score_p1     in   4  player-1 score (0-9 valid, 10-15 shown as dash)
//   score_p2     in   4  player-2 score (0-9 valid, 10-15 shown as dash)
//   clk_1k       out  1  50% duty divided clock at FAST_HZ
//   clk_10       out  1  50% duty divided clock at SLOW_HZ
//   counter_0    out  1  bit 0 of the slow divider counter
//   segments     out  8  {dp,g,f,e,d,c,b,a}, active-high
//   cathode_sel  out  3  digit select, 0 = player 1, 1 = player 2

module pong_timebase_display #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FAST_HZ     = 1_000,
  parameter int SLOW_HZ     = 10,
  parameter int SCAN_HZ     = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  output logic       clk_1k,
  output logic       clk_10,
  output logic       counter_0,
  output logic [7:0] segments,
  output logic [2:0] cathode_sel
);

  // Half-period counts, clamped so a degenerate parameter set still divides by 2.
  localparam int NF_RAW = CLK_FREQ_HZ / (2 * FAST_HZ);
  localparam int NS_RAW = CLK_FREQ_HZ / (2 * SLOW_HZ);
  localparam int NX_RAW = CLK_FREQ_HZ / (2 * SCAN_HZ);
  localparam int NF = (NF_RAW < 1) ? 1 : NF_RAW;
  localparam int NS = (NS_RAW < 1) ? 1 : NS_RAW;
  localparam int NX = (NX_RAW < 1) ? 1 : NX_RAW;

  localparam int FW = (NF > 1) ? $clog2(NF) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;

  localparam logic [FW-1:0] F_MAX = FW'(NF - 1);
  localparam logic [SW-1:0] S_MAX = SW'(NS - 1);
  localparam logic [XW-1:0] X_MAX = XW'(NX - 1);

  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic [XW-1:0] scan_cnt_q, scan_cnt_d;
  logic          fast_clk_q, fast_clk_d;
  logic          slow_clk_q, slow_clk_d;
  logic          sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    fast_cnt_d = fast_cnt_q + FW'(1);
    fast_clk_d = fast_clk_q;
    if (fast_cnt_q == F_MAX) begin
      fast_cnt_d = '0;
      fast_clk_d = ~fast_clk_q;
    end

    slow_cnt_d = slow_cnt_q + SW'(1);
    slow_clk_d = slow_clk_q;
    if (slow_cnt_q == S_MAX) begin
      slow_cnt_d = '0;
      slow_clk_d = ~slow_clk_q;
    end

    scan_cnt_d = scan_cnt_q + XW'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == X_MAX) begin
      scan_cnt_d = '0;
      sel_d      = ~sel_q;
    end

    // Decode from the next select value so segments and cathode_sel
    // always describe the same digit in any given cycle.
    seg_d = {1'b0, decode(sel_d ? score_p2 : score_p1)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fast_cnt_q <= '0;
      slow_cnt_q <= '0;
      scan_cnt_q <= '0;
      fast_clk_q <= 1'b0;
      slow_clk_q <= 1'b0;
      sel_q      <= 1'b0;
      seg_q      <= 8'h00;
    end else begin
      fast_cnt_q <= fast_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      fast_clk_q <= fast_clk_d;
      slow_clk_q <= slow_clk_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign clk_1k      = fast_clk_q;
  assign clk_10      = slow_clk_q;
  assign counter_0   = slow_cnt_q[0];
  assign segments    = seg_q;
  assign cathode_sel = {2'b00, sel_q};

endmodule

// File: tb/tb_pong_timebase_display.sv
// tb/tb_pong_timebase_display.sv - self-checking bench for pong_timebase_display

module tb_pong_timebase_display;

  localparam int NF = 5;
  localparam int NS = 50;
  localparam int NX = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] score_p1 = 4'd0;
  logic [3:0] score_p2 = 4'd0;
  logic       clk_1k, clk_10, counter_0;
  logic [7:0] segments;
  logic [2:0] cathode_sel;

  pong_timebase_display #(
    .CLK_FREQ_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10), .SCAN_HZ(50)
  ) dut (
    .clk(clk), .reset(reset), .score_p1(score_p1), .score_p2(score_p2),
    .clk_1k(clk_1k), .clk_10(clk_10), .counter_0(counter_0),
    .segments(segments), .cathode_sel(cathode_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fast;
    logic       slow;
    logic       c0;
    logic [2:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] seg_tbl [16];
  int         n = 0;       // non-reset edges since the last reset edge
  int         checks = 0;
  int         passes = 0;

  // Drive inputs away from the edge, push the expected post-edge outputs,
  // then advance one clock and settle.
  task automatic tick(input logic rst, input logic [3:0] p1, input logic [3:0] p2);
    exp_t e;
    reset    = rst;
    score_p1 = p1;
    score_p2 = p2;
    if (rst) begin
      n = 0;
      e.fast = 1'b0; e.slow = 1'b0; e.c0 = 1'b0; e.sel = 3'd0; e.seg = 8'h00;
    end else begin
      n = n + 1;
      e.fast = ((n / NF) % 2) == 1;
      e.slow = ((n / NS) % 2) == 1;
      e.c0   = ((n % NS) % 2) == 1;
      e.sel  = 3'((n / NX) % 2);
      e.seg  = seg_tbl[(e.sel == 3'd1) ? p2 : p1];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'd5, 4'd6);
      e = sb_q.pop_front();
      checks++;
      if ({clk_1k, clk_10, counter_0, cathode_sel, segments} !== 14'd0)
        $display("FAIL reset_state cyc%0d: got %b/%b/%b/%0d/%h want 0/0/0/0/00",
                 i, clk_1k, clk_10, counter_0, cathode_sel, segments);
      else passes++;
    end
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 4'd0, 4'd0);
      e = sb_q.pop_front();
      checks++;
      if (clk_1k !== ((i == 5) ? 1'b1 : 1'b0))
        $display("FAIL first_rise n=%0d: clk_1k=%b want %b", i, clk_1k, (i == 5));
      else passes++;
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    logic pf, ps;
    int   f_rise, f_fall, s_rise, s_fall;
    pf = clk_1k; ps = clk_10;
    f_rise = -1; f_fall = -1; s_rise = -1; s_fall = -1;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, 4'd1, 4'd2);
      e = sb_q.pop_front();
      checks++;
      if (clk_1k !== e.fast || clk_10 !== e.slow)
        $display("FAIL free_run n=%0d: clk_1k=%b clk_10=%b want %b %b", n, clk_1k, clk_10, e.fast, e.slow);
      else passes++;
      if (!pf && clk_1k) begin
        if (f_rise >= 0) begin
          checks++;
          if (n - f_rise !== 10) $display("FAIL fast_period: got %0d want 10", n - f_rise);
          else passes++;
        end
        f_rise = n;
      end
      if (pf && !clk_1k && f_rise >= 0) begin
        checks++;
        if (n - f_rise !== 5) $display("FAIL fast_high: got %0d want 5", n - f_rise);
        else passes++;
      end
      if (!ps && clk_10) begin
        if (s_rise >= 0) begin
          checks++;
          if (n - s_rise !== 100) $display("FAIL slow_period: got %0d want 100", n - s_rise);
          else passes++;
        end
        s_rise = n;
      end
      if (ps && !clk_10 && s_rise >= 0) begin
        checks++;
        if (n - s_rise !== 50) $display("FAIL slow_high: got %0d want 50", n - s_rise);
        else passes++;
      end
      pf = clk_1k; ps = clk_10;
    end
  endtask

  task automatic test_score_mux();
    exp_t e;
    logic [2:0] psel;
    int   last_tog;
    psel = cathode_sel;
    last_tog = -1;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 4'd3, 4'd7);
      e = sb_q.pop_front();
      checks++;
      if (cathode_sel !== e.sel || segments !== ((cathode_sel == 3'd1) ? 8'h07 : 8'h4F))
        $display("FAIL mux_3_7 n=%0d: sel=%0d seg=%h want sel=%0d seg=%h",
                 n, cathode_sel, segments, e.sel, (e.sel == 3'd1) ? 8'h07 : 8'h4F);
      else passes++;
      if (cathode_sel !== psel) begin
        if (last_tog >= 0) begin
          checks++;
          if (n - last_tog !== 10) $display("FAIL sel_toggle: got %0d want 10", n - last_tog);
          else passes++;
        end
        last_tog = n;
      end
      psel = cathode_sel;
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    logic [3:0] v;
    for (int k = 0; k <= 10; k++) begin
      v = (k == 10) ? 4'd12 : 4'(k);
      for (int j = 0; j < 2; j++) begin
        tick(1'b0, v, v);
        e = sb_q.pop_front();
        checks++;
        if (segments !== e.seg) $display("FAIL sweep v=%0d: seg=%h want %h", v, segments, e.seg);
        else passes++;
      end
      for (int j = 0; j < 20; j++) begin
        tick(1'b0, v, 4'd9 - ((k == 10) ? 4'd0 : 4'(k)));
        e = sb_q.pop_front();
        checks++;
        if (segments !== e.seg || cathode_sel !== e.sel)
          $display("FAIL sweep_pair v=%0d n=%0d: sel=%0d seg=%h want %0d %h",
                   v, n, cathode_sel, segments, e.sel, e.seg);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      e = sb_q.pop_front();
      checks++;
      if (segments !== e.seg || cathode_sel !== e.sel)
        $display("FAIL back_to_back n=%0d: sel=%0d seg=%h want %0d %h", n, cathode_sel, segments, e.sel, e.seg);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   budget;
    budget = 0;
    while (!((n / NS) % 2 == 1 && (n % NS) == 25) && budget < 300) begin
      tick(1'b0, 4'd4, 4'd8);
      e = sb_q.pop_front();
      budget++;
    end
    checks++;
    if (clk_10 !== 1'b1 || budget >= 300) $display("FAIL mid_high_reach: clk_10=%b budget=%0d want 1", clk_10, budget);
    else passes++;
    tick(1'b1, 4'd4, 4'd8);
    e = sb_q.pop_front();
    checks++;
    if (clk_10 !== 1'b0 || clk_1k !== 1'b0 || segments !== 8'h00)
      $display("FAIL mid_reset: clk_10=%b clk_1k=%b seg=%h want 0 0 00", clk_10, clk_1k, segments);
    else passes++;
    for (int i = 1; i <= 50; i++) begin
      tick(1'b0, 4'd4, 4'd8);
      e = sb_q.pop_front();
      checks++;
      if (clk_10 !== ((i == 50) ? 1'b1 : 1'b0) || clk_1k !== e.fast)
        $display("FAIL mid_restart i=%0d: clk_10=%b clk_1k=%b want %b %b", i, clk_10, clk_1k, (i == 50), e.fast);
      else passes++;
    end
  endtask

  task automatic test_counter0();
    exp_t e;
    logic prev;
    prev = counter_0;
    for (int i = 0; i < 120; i++) begin
      tick(1'b0, 4'd0, 4'd1);
      e = sb_q.pop_front();
      checks++;
      if ((n % NS) == 0) begin
        if (counter_0 !== 1'b0) $display("FAIL c0_wrap n=%0d: got %b want 0", n, counter_0);
        else passes++;
      end else begin
        if (counter_0 !== ~prev || counter_0 !== e.c0)
          $display("FAIL c0_alt n=%0d: got %b want %b", n, counter_0, e.c0);
        else passes++;
      end
      prev = counter_0;
    end
  endtask

  initial begin
    seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    @(negedge clk);
    test_reset();
    test_free_run();
    test_score_mux();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    test_counter0();
    checks++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
